load_miss_controller: RTL

//  Next-generation data-cache load-side controller, between the LDU and the data cache arrays and memory channels.

---
 rtl/load_miss_controller.sv | 111 +++++++++++
 1 files changed

// File: rtl/load_miss_controller.sv
// load_miss_controller: data-cache load controller with write-back eviction and critical-word-first fill
module load_miss_controller #(
  parameter int OFFSET = 2,
  parameter int INDEX = 12,
  parameter bit WRITE_BACK = 1'b1,
  parameter bit CRITICAL_FIRST = 1'b1,
  localparam int TAG = 30 - INDEX - OFFSET
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           invalidate_i,
  input  logic           request_i,
  input  logic [31:0]    address_i,
  output logic           ready_o,
  output logic [31:0]    data_o,
  output logic           valid_o,
  output logic           mem_ld_request_o,
  output logic [31:0]    mem_ld_address_o,
  input  logic           mem_ld_ready_i,
  input  logic           mem_ld_valid_i,
  input  logic [31:0]    mem_ld_data_i,
  output logic           mem_st_request_o,
  output logic [31:0]    mem_st_address_o,
  output logic [31:0]    mem_st_data_o,
  input  logic           mem_st_ready_i,
  input  logic           cache_hit_i,
  input  logic           cache_dirty_i,
  input  logic [TAG-1:0] cache_tag_i,
  output logic [31:0]    cache_address_o,
  output logic [1:0]     cache_read_o,
  output logic [1:0]     cache_write_o,
  input  logic [31:0]    cache_data_i,
  output logic [31:0]    cache_data_o,
  output logic           cache_valid_o,
  output logic           cache_dirty_o
);
  localparam int BW = 2 ** OFFSET;
  typedef enum logic [2:0] {IDLE, LOOKUP, EVICT_RD, EVICT_WR, FILL} state_t;
  state_t state;
  logic [31:0] addr_q, evict_a, fill_a;
  logic [TAG-1:0] vtag_q, tag;
  logic [INDEX-1:0] index;
  logic [OFFSET-1:0] w, s_q, v_q, rq_w, rs_w;
  logic [OFFSET:0] rq_q, rs_q;
  logic inv_q, inv, ld_fire, st_fire, rs_last, hit_v, fill_v;
  always_comb begin
    tag = addr_q[31:32-TAG];
    index = addr_q[OFFSET+INDEX+1:OFFSET+2];
    w = addr_q[OFFSET+1:2];
    rq_w = s_q + rq_q[OFFSET-1:0];
    rs_w = s_q + rs_q[OFFSET-1:0];
    evict_a = {vtag_q, index, v_q, 2'b00};
    fill_a = {tag, index, rs_w, 2'b00};
    inv = inv_q | invalidate_i;
    rs_last = rs_q == (OFFSET+1)'(BW - 1);
    hit_v = state == LOOKUP && cache_hit_i && !inv;
    fill_v = state == FILL && mem_ld_valid_i && rs_w == w && !inv;
    ready_o = state == IDLE;
    valid_o = hit_v | fill_v;
    data_o = hit_v ? cache_data_i : fill_v ? mem_ld_data_i : '0;
    mem_ld_request_o = state == FILL && !rq_q[OFFSET];
    mem_ld_address_o = {tag, index, rq_w, 2'b00};
    ld_fire = mem_ld_request_o & mem_ld_ready_i;
    mem_st_request_o = WRITE_BACK && state == EVICT_WR;
    mem_st_address_o = WRITE_BACK ? evict_a : '0;
    mem_st_data_o = mem_st_request_o ? cache_data_i : '0;
    st_fire = mem_st_request_o & mem_st_ready_i;
    cache_address_o = state == IDLE ? address_i : state == LOOKUP ? addr_q : state == FILL ? fill_a : evict_a;
    cache_read_o = state == IDLE ? {2{request_i & ~invalidate_i}} :
                   (state == EVICT_RD || state == EVICT_WR) ? 2'b01 : 2'b00;
    cache_write_o = state == FILL && mem_ld_valid_i ? {rs_q == '0, 1'b1} : 2'b00;
    cache_data_o = cache_write_o[0] ? mem_ld_data_i : '0;
    cache_valid_o = cache_write_o[1];
    cache_dirty_o = 1'b0;
  end
  always_ff @(posedge clk_i)
    if (rst_i) begin
      state <= IDLE;
      addr_q <= '0;
      vtag_q <= '0;
      s_q <= '0;
      v_q <= '0;
      rq_q <= '0;
      rs_q <= '0;
      inv_q <= 1'b0;
    end else begin
      assert (!mem_ld_valid_i || (state == FILL && rs_q < rq_q));
      inv_q <= state != IDLE && inv;
      rq_q <= state == FILL ? rq_q + (OFFSET+1)'(ld_fire) : '0;
      rs_q <= state == FILL ? rs_q + (OFFSET+1)'(mem_ld_valid_i) : '0;
      case (state)
        IDLE: if (request_i && !invalidate_i) begin
          addr_q <= address_i;
          state <= LOOKUP;
        end
        LOOKUP: begin
          s_q <= CRITICAL_FIRST ? w : '0;
          vtag_q <= cache_tag_i;
          v_q <= '0;
          state <= inv || cache_hit_i ? IDLE : WRITE_BACK && cache_dirty_i ? EVICT_RD : FILL;
        end
        EVICT_RD: state <= EVICT_WR;
        EVICT_WR: if (st_fire) begin
          v_q <= v_q + OFFSET'(1);
          state <= v_q != '1 ? EVICT_RD : inv ? IDLE : FILL;
        end
        FILL: if (mem_ld_valid_i && rs_last) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
endmodule
